// File: rtl/fdivision_multi.sv
// -----------------------------------------------------------------------------
// fdivision_multi
//
// Multi-channel programmable clock divider. Each of the CH channels divides the
// Fin clock by its own runtime-loadable divisor. The output is either a 50%
// duty toggled clock (mode 0) or a one-cycle pulse (mode 1). A terminal-count
// tick is produced in both modes.
//
// Ports:
//   Fin       in   1      system clock, all logic on the rising edge
//   reset     in   1      asynchronous active-high reset
//   enable    in   CH     per-channel run enable
//   mode      in   CH     per-channel mode: 0 = toggle, 1 = pulse
//   div_we    in   1      divisor write strobe (one Fin cycle)
//   div_sel   in   SELW   channel index for the divisor write
//   div_data  in   WIDTH  new divisor value (0 behaves as 1)
//   sync_clr  in   1      synchronous phase clear of every channel
//   Fout      out  CH     divided clock outputs
//   tick      out  CH     one-cycle terminal-count pulse per channel
// -----------------------------------------------------------------------------
module fdivision_multi #(
  parameter int          CH          = 3,
  parameter int          WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 1000000,
  parameter int          SELW        = 3
) (
  input  logic             Fin,
  input  logic             reset,
  input  logic [CH-1:0]    enable,
  input  logic [CH-1:0]    mode,
  input  logic             div_we,
  input  logic [SELW-1:0]  div_sel,
  input  logic [WIDTH-1:0] div_data,
  input  logic             sync_clr,
  output logic [CH-1:0]    Fout,
  output logic [CH-1:0]    tick
);

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             fout_q, fout_d;
    logic             tick_q, tick_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] de;
    logic             wr_hit;
    logic             term;

    // A zero divisor behaves as divide-by-one so the channel can never stall.
    assign de     = (div_q == '0) ? WIDTH'(1) : div_q;
    // An out-of-range div_sel never matches any channel, so it is ignored.
    assign wr_hit = div_we && (div_sel == SELW'(gi));
    assign term   = enable[gi] && (cnt_q == de - WIDTH'(1));

    always_comb begin
      cnt_d    = cnt_q;
      div_d    = div_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      fout_d   = fout_q;
      tick_d   = 1'b0;
      mode_d   = mode[gi];

      if (sync_clr) begin
        // Phase clear: a same-cycle write goes straight to the divisor,
        // otherwise any pending shadow is committed now.
        cnt_d  = '0;
        fout_d = 1'b0;
        if (wr_hit) begin
          div_d = div_data;
        end else if (pend_q) begin
          div_d = shadow_q;
        end
        pend_d = 1'b0;
      end else begin
        if (mode[gi] != mode_q) begin
          // Restart the channel cleanly in the new mode.
          cnt_d  = '0;
          fout_d = 1'b0;
        end else if (term) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          fout_d = mode_q ? 1'b1 : ~fout_q;
          // The period that just ended ran at the old divisor; the new one
          // takes over from here, so no runt period is produced.
          if (pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
          end
        end else begin
          if (enable[gi]) begin
            cnt_d = cnt_q + WIDTH'(1);
          end
          // Pulse mode output is high only on the terminal cycle.
          if (mode_q) begin
            fout_d = 1'b0;
          end
        end

        // Writes after the terminal handling so a write landing on a terminal
        // cycle becomes the next pending value rather than being lost.
        if (wr_hit) begin
          if (enable[gi]) begin
            shadow_d = div_data;
            pend_d   = 1'b1;
          end else begin
            div_d  = div_data;
            cnt_d  = '0;
            pend_d = 1'b0;
          end
        end
      end
    end

    always_ff @(posedge Fin or posedge reset) begin
      if (reset) begin
        cnt_q    <= '0;
        div_q    <= WIDTH'(DEFAULT_DIV);
        shadow_q <= '0;
        pend_q   <= 1'b0;
        fout_q   <= 1'b0;
        tick_q   <= 1'b0;
        mode_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        div_q    <= div_d;
        shadow_q <= shadow_d;
        pend_q   <= pend_d;
        fout_q   <= fout_d;
        tick_q   <= tick_d;
        mode_q   <= mode_d;
      end
    end

    assign Fout[gi] = fout_q;
    assign tick[gi] = tick_q;
  end

endmodule
